aidc_lite_line_out: RTL and testbench
=====================================

# aidc_lite_line_out

Output stage placed directly downstream of the AIDC-Lite code concatenator. It captures the uncompressed 512-bit line when compression starts and collects the concatenator's addressed 64-bit word writes into an 8-word line buffer. When the concatenator signals done, it emits one 512-bit line on a valid/ready interface: the compressed line if the block fit, or the raw line if compression failed.

## Interface
- Parameters
  - `NUM_WORDS`, 8: words per line; address width is 3 bits.
  - `WORD_SIZE`, 64: bits per word; line width is `NUM_WORDS*WORD_SIZE` = 512.
- Ports
  - `clk` in 1: clock.
  - `rst_n` in 1: reset, synchronous, active-low.
  - `raw_valid_i` in 1: a raw line is offered; the concatenator is launched in the same cycle.
  - `raw_ready_o` out 1: the block can accept a raw line.
  - `raw_data_i` in 512: raw line.
  - `wr_valid_i` in 1: concatenator word write.
  - `wr_addr_i` in 3: word index; 0 is the first word.
  - `wr_data_i` in 64: word data.
  - `done_i` in 1: concatenator done (level).
  - `fail_i` in 1: concatenator fail; valid when `done_i`=1.
  - `out_valid_o` out 1: output line valid.
  - `out_ready_i` in 1: consumer accepts.
  - `out_data_o` out 512: output line.
  - `out_comp_o` out 1: 1 = compressed line, 0 = raw line.
  - `out_words_o` out 4: number of meaningful words, 1..8.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, OUT.
- IDLE
  - `raw_ready_o`=1.
  - On `raw_valid_i`: store `raw_data_i`, clear the word buffer to 0, set `max_cnt`=0, and go to WAIT_BUSY.
- WAIT_BUSY
  - The concatenator's `done_i` is still 1 for one or more cycles after launch.
  - Stay until `done_i`=0, then go to WAIT_DONE.
  - Capture writes in this state.
- WAIT_DONE
  - Capture writes.
  - On `done_i`=1: latch `fail_i` and go to OUT.
- Write capture, in WAIT_BUSY and WAIT_DONE only
  - `buf[511-64*addr -: 64] <= wr_data_i`, so word 0 occupies the MSBs.
  - `max_cnt <= max(max_cnt, addr+1)`.
  - A write in the same cycle that `done_i` rises is captured and included in the output.
  - A repeated address overwrites the earlier word.
  - Writes in IDLE or OUT are ignored.
- OUT
  - `out_valid_o`=1.
  - If the latched fail is 0: `out_data_o`=buffer (unwritten words 0), `out_comp_o`=1, `out_words_o`=`max_cnt`.
  - If the latched fail is 1: `out_data_o`=raw line, `out_comp_o`=0, `out_words_o`=8.
  - If the latched fail is 0 but `max_cnt`=0, treat it as fail (raw output).
  - On `out_ready_i`=1: go to IDLE.
- Output fields are registered and held stable while `out_valid_o`=1 and `out_ready_i`=0.
- `raw_ready_o`=0 in every state except IDLE, so only one line is in flight.
- `fail_i` outside OUT entry has no effect.

## Timing
- Reset values
  - State IDLE, so `raw_ready_o`=1.
  - `out_valid_o`=0, `out_data_o`=0, `out_comp_o`=0, `out_words_o`=0.
  - Buffer and `max_cnt` are 0.
- Reset asserted mid-operation aborts the line: no output is produced and the state returns to IDLE on the next edge.
- Raw accept edge T0: state WAIT_BUSY from T0+1.
- `done_i` sampled 1 in WAIT_DONE at edge T: `out_valid_o`=1 from T+1.
  - Latency is 1 cycle from done to output valid.
- Handshake completes at the edge where `out_valid_o`=1 and `out_ready_i`=1.
  - `out_valid_o`=0 and `raw_ready_o`=1 from the next cycle.
  - Minimum line period is 4 cycles plus the concatenator time.
- `done_i` high in IDLE or OUT is ignored; only the 1→0→1 sequence after a launch completes a line.

## Test plan
- **Compressed line**
  - Stimulus: accept raw=R; `done_i` 1 then 0; writes addr 0..2 data A,B,C; done=1, fail=0 on the cycle of the addr-2 write.
  - Required: next cycle `out_valid_o`=1, data = {A,B,C,320'h0}, `out_comp_o`=1, `out_words_o`=3.
- **Fail path**
  - Stimulus: 8 writes, then done with fail=1.
  - Required: out = R, `out_comp_o`=0, `out_words_o`=8.
- **Backpressure**
  - Stimulus: hold `out_ready_i`=0 for 5 cycles in OUT; toggle `wr_valid_i`, `raw_valid_i`, `done_i`.
  - Required: outputs stable; `raw_ready_o`=0; no state change.
  - Stimulus: set ready=1.
  - Required: IDLE next cycle.
- **Stale done**
  - Stimulus: `done_i` held 1 for 3 cycles after launch, then 0 for 4, then 1.
  - Required: the output fires only after the final rise, one cycle later.
- **Overwrite and zero words**
  - Stimulus: write addr 1 twice (X then Y), addr 0 = Z, done with fail=0.
  - Required: data = {Z,Y,384'h0}, `out_words_o`=2.
  - Stimulus: done with no writes and fail=0.
  - Required: raw output with `out_comp_o`=0.
- **Reset mid-collect**
  - Stimulus: assert `rst_n`=0 during WAIT_DONE.
  - Required: all outputs equal their reset values, `raw_ready_o`=1, and no spurious `out_valid_o`.

Source files
------------

// File: rtl/aidc_lite_line_out.sv
// AIDC-Lite line output stage: collects concatenator word writes into a
// line buffer and emits either the compressed line or the raw line.
module aidc_lite_line_out #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_SIZE = 64,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int CW = $clog2(NUM_WORDS + 1),
  localparam int LW = NUM_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 raw_valid_i,
  output logic                 raw_ready_o,
  input  logic [LW-1:0]        raw_data_i,
  input  logic                 wr_valid_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic                 done_i,
  input  logic                 fail_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LW-1:0]        out_data_o,
  output logic                 out_comp_o,
  output logic [CW-1:0]        out_words_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] raw_q, raw_d;
  logic [LW-1:0] buf_q, buf_d;
  logic [CW-1:0] max_q, max_d;
  logic          raw_ready_q, raw_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] out_data_q, out_data_d;
  logic          out_comp_q, out_comp_d;
  logic [CW-1:0] out_words_q, out_words_d;

  logic          capture;
  logic          finish;
  logic          use_raw;
  logic [CW-1:0] wr_cnt;

  always_comb begin
    state_d     = state_q;
    raw_d       = raw_q;
    buf_d       = buf_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_comp_d  = out_comp_q;
    out_words_d = out_words_q;
    capture     = 1'b0;
    finish      = 1'b0;
    use_raw     = 1'b0;
    wr_cnt      = CW'(wr_addr_i) + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (raw_valid_i) begin
          raw_d   = raw_data_i;
          buf_d   = '0;
          max_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        capture = 1'b1;
        if (!done_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        capture = 1'b1;
        if (done_i) begin
          finish  = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word 0 lands in the MSBs of the line.
    if (capture && wr_valid_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr_addr_i == AW'(i))
          buf_d[LW-1-WORD_SIZE*i -: WORD_SIZE] = wr_data_i;
      end
      if (wr_cnt > max_q) max_d = wr_cnt;
    end

    // An empty compressed line is meaningless, so fall back to raw.
    if (finish) begin
      use_raw     = fail_i || (max_d == '0);
      out_valid_d = 1'b1;
      out_data_d  = use_raw ? raw_q : buf_d;
      out_comp_d  = !use_raw;
      out_words_d = use_raw ? CW'(NUM_WORDS) : max_d;
    end

    raw_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      raw_q       <= '0;
      buf_q       <= '0;
      max_q       <= '0;
      raw_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_comp_q  <= 1'b0;
      out_words_q <= '0;
    end else begin
      state_q     <= state_d;
      raw_q       <= raw_d;
      buf_q       <= buf_d;
      max_q       <= max_d;
      raw_ready_q <= raw_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_comp_q  <= out_comp_d;
      out_words_q <= out_words_d;
    end
  end

  assign raw_ready_o = raw_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_comp_o  = out_comp_q;
  assign out_words_o = out_words_q;

endmodule

// File: tb/tb_aidc_lite_line_out.sv
// Directed bench for aidc_lite_line_out: compressed, raw-fallback,
// backpressure, stale done, overwrite and reset scenarios.
module tb_aidc_lite_line_out;

  logic         clk;
  logic         rst_n;
  logic         raw_valid_i;
  logic         raw_ready_o;
  logic [511:0] raw_data_i;
  logic         wr_valid_i;
  logic [2:0]   wr_addr_i;
  logic [63:0]  wr_data_i;
  logic         done_i;
  logic         fail_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [511:0] out_data_o;
  logic         out_comp_o;
  logic [3:0]   out_words_o;

  int checks = 0;
  int errors = 0;

  aidc_lite_line_out dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_valid_i (raw_valid_i),
    .raw_ready_o (raw_ready_o),
    .raw_data_i  (raw_data_i),
    .wr_valid_i  (wr_valid_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .done_i      (done_i),
    .fail_i      (fail_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_comp_o  (out_comp_o),
    .out_words_o (out_words_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs settle #1 after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    raw_valid_i = 1'b0;
    wr_valid_i  = 1'b0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    fail_i      = 1'b0;
    out_ready_i = 1'b0;
  endtask

  // Accept a raw line; done is still high from the previous run.
  task automatic launch(input logic [511:0] r);
    raw_valid_i = 1'b1;
    raw_data_i  = r;
    done_i      = 1'b1;
    tick();
    raw_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
  endtask

  task automatic test_reset();
    quiet();
    done_i     = 1'b0;
    raw_data_i = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 512'h0 ||
        out_comp_o !== 1'b0 || out_words_o !== 4'd0 ||
        raw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset: v=%b c=%b w=%0d rr=%b need 0 0 0 1",
               out_valid_o, out_comp_o, out_words_o, raw_ready_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_compressed();
    logic [511:0] r;
    logic [511:0] exp;
    r   = {8{64'hDEAD_BEEF_0123_4567}};
    exp = {64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
           64'hCCCC_0000_0000_0003, 320'h0};
    quiet();
    launch(r);
    checks++;
    if (raw_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL comp_rr_busy: got %b need 0", raw_ready_o);
    end
    done_i = 1'b0;
    tick();
    wr(3'd0, 64'hAAAA_0000_0000_0001);
    tick();
    wr(3'd1, 64'hBBBB_0000_0000_0002);
    tick();
    wr(3'd2, 64'hCCCC_0000_0000_0003);
    done_i = 1'b1;
    fail_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL comp_early_valid: got %b need 0", out_valid_o);
    end
    tick();
    wr_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== exp ||
        out_comp_o !== 1'b1 || out_words_o !== 4'd3) begin
      errors++;
      $display("FAIL comp_line: v=%b c=%b w=%0d d=%h need 1 1 3 %h",
               out_valid_o, out_comp_o, out_words_o, out_data_o, exp);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || raw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL comp_handshake: v=%b rr=%b need 0 1",
               out_valid_o, raw_ready_o);
    end
  endtask

  task automatic test_fail();
    logic [511:0] r;
    r = {16{32'h1357_9BDF}};
    quiet();
    launch(r);
    done_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), {32'h5555_0000, 32'(i)});
      tick();
    end
    wr_valid_i = 1'b0;
    done_i     = 1'b1;
    fail_i     = 1'b1;
    tick();
    fail_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== r ||
        out_comp_o !== 1'b0 || out_words_o !== 4'd8) begin
      errors++;
      $display("FAIL fail_path: v=%b c=%b w=%0d d=%h need 1 0 8 %h",
               out_valid_o, out_comp_o, out_words_o, out_data_o, r);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [511:0] exp;
    exp = {64'h0123_4567_89AB_CDEF, 448'h0};
    quiet();
    launch({8{64'h7777_7777_7777_7777}});
    done_i = 1'b0;
    tick();
    wr(3'd0, 64'h0123_4567_89AB_CDEF);
    done_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr(3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      wr_valid_i  = i[0];
      raw_valid_i = ~i[0];
      raw_data_i  = {16{32'hBAD0_BAD0}};
      done_i      = i[0];
      tick();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp ||
          out_comp_o !== 1'b1 || out_words_o !== 4'd1 ||
          raw_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b c=%b w=%0d rr=%b need 1 1 1 0",
                 i, out_valid_o, out_comp_o, out_words_o, raw_ready_o);
      end
    end
    quiet();
    done_i      = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || raw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: v=%b rr=%b need 0 1",
               out_valid_o, raw_ready_o);
    end
  endtask

  task automatic test_stale_done();
    logic [511:0] exp;
    logic         early;
    exp          = '0;
    exp[255:192] = 64'hEEEE_1234_5678_9999;
    early        = 1'b0;
    quiet();
    launch({8{64'h4444_4444_4444_4444}});
    for (int i = 0; i < 3; i++) begin
      done_i = 1'b1;
      tick();
      if (out_valid_o !== 1'b0) early = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      done_i = 1'b0;
      if (i == 1) wr(3'd4, 64'hEEEE_1234_5678_9999);
      else wr_valid_i = 1'b0;
      tick();
      if (out_valid_o !== 1'b0) early = 1'b1;
    end
    wr_valid_i = 1'b0;
    done_i     = 1'b1;
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL stale_early: got valid before final rise");
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== exp ||
        out_comp_o !== 1'b1 || out_words_o !== 4'd5) begin
      errors++;
      $display("FAIL stale_line: v=%b c=%b w=%0d d=%h need 1 1 5 %h",
               out_valid_o, out_comp_o, out_words_o, out_data_o, exp);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_overwrite();
    logic [511:0] exp;
    exp = {64'h2222_0000_0000_000Z & 64'h2222_0000_0000_0000,
           64'hB0B0_B0B0_B0B0_B0B0, 384'h0};
    quiet();
    launch({8{64'h9999_9999_9999_9999}});
    done_i = 1'b0;
    tick();
    wr(3'd1, 64'hA0A0_A0A0_A0A0_A0A0);
    tick();
    wr(3'd1, 64'hB0B0_B0B0_B0B0_B0B0);
    tick();
    wr(3'd0, 64'h2222_0000_0000_0000);
    tick();
    wr_valid_i = 1'b0;
    done_i     = 1'b1;
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== exp ||
        out_comp_o !== 1'b1 || out_words_o !== 4'd2) begin
      errors++;
      $display("FAIL overwrite: v=%b c=%b w=%0d d=%h need 1 1 2 %h",
               out_valid_o, out_comp_o, out_words_o, out_data_o, exp);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_zero_words();
    logic [511:0] r;
    r = {16{32'hC0DE_F00D}};
    quiet();
    launch(r);
    done_i = 1'b0;
    tick();
    tick();
    done_i = 1'b1;
    fail_i = 1'b0;
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== r ||
        out_comp_o !== 1'b0 || out_words_o !== 4'd8) begin
      errors++;
      $display("FAIL zero_words: v=%b c=%b w=%0d d=%h need 1 0 8 %h",
               out_valid_o, out_comp_o, out_words_o, out_data_o, r);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic spurious;
    spurious = 1'b0;
    quiet();
    launch({8{64'h3333_3333_3333_3333}});
    done_i = 1'b0;
    tick();
    wr(3'd3, 64'h6666_6666_6666_6666);
    tick();
    wr_valid_i = 1'b0;
    rst_n      = 1'b0;
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 512'h0 ||
        out_comp_o !== 1'b0 || out_words_o !== 4'd0 ||
        raw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: v=%b c=%b w=%0d rr=%b need 0 0 0 1",
               out_valid_o, out_comp_o, out_words_o, raw_ready_o);
    end
    rst_n  = 1'b1;
    done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid_o !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0 || raw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: spurious=%b rr=%b need 0 1",
               spurious, raw_ready_o);
    end
    done_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_compressed();
    test_fail();
    test_backpressure();
    test_stale_done();
    test_overwrite();
    test_zero_words();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
